spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master transfer controller that sequences single- and multi-frame SPI transactions for the SPI subsystem. It accepts frames over a valid/ready request interface and generates SCLK from the system clock using a programmable half-period divider. It drives CS_N/MOSI, samples MISO, and returns each received frame on a response strobe. It replaces free-running divided clocks with an edge-strobe scheme, so all logic stays on `clk`.

## Interface
- DIV_W, 8, width of the half-period divider field
- DATA_W, 8, frame width in bits (MSB first)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk cycles
- cfg_cpol  in  1  SCLK idle level
- cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- req_valid  in  1  request frame available
- req_ready  out  1  controller accepts request this cycle
- req_data  in  DATA_W  frame to transmit
- req_last  in  1  deassert CS_N after this frame
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  DATA_W  received frame
- busy  out  1  high whenever state != IDLE
- sclk  out  1  SPI clock, registered
- mosi  out  1  SPI data out, registered
- miso  in  1  SPI data in; synchronised externally
- cs_n  out  1  chip select, active low, registered

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- `req_ready` = (state==IDLE || state==GAP), combinational. Handshake = req_valid && req_ready.
- IDLE:
  - sclk follows cfg_cpol; cs_n=1.
  - On handshake, latch cfg_div/cfg_cpol/cfg_cpha/req_data/req_last, then go to SETUP.
  - Config is never relatched outside IDLE.
- SETUP:
  - cs_n=0 for H=cfg_div+1 cycles.
  - If CPHA=0, MOSI presents the MSB on entry.
  - Then go to SHIFT.
- SHIFT:
  - 2*DATA_W SCLK edges, one every H cycles; each edge toggles sclk.
  - Odd edges are leading, even edges are trailing.
  - CPHA=0: sample MISO on leading edges; shift MOSI on trailing edges, except after the final edge.
  - CPHA=1: drive MOSI on leading edges; sample on trailing edges.
  - After the final edge, go to HOLD.
- HOLD:
  - Lasts H cycles with cs_n=0.
  - Then go to IDLE (cs_n←1) if the latched last=1, else go to GAP.
- GAP:
  - cs_n stays 0 and sclk stays at cpol.
  - On handshake, latch req_data/req_last only, then go to SETUP.
  - No timeout.
- rsp_valid pulses one cycle on the cycle after the final sampling edge, with rsp_data = shifted-in frame. There is no backpressure; rsp_data holds until the next pulse.
- Edge timing comes from a half-period counter that is reset on every state entry and wraps at cfg_div. cfg_div=0 gives SCLK = clk/2.

## Timing
- Reset values:
  - sclk=0, cs_n=1, mosi=0, rsp_valid=0, rsp_data=0, busy=0.
  - state=IDLE, so req_ready=1.
  - Assertion of rst_n mid-frame forces these values immediately. No partial rsp_valid is produced.
- Frame from handshake at cycle T, all states taking whole multiples of H:
  - cs_n falls at T+1.
  - First SCLK edge at T+1+H.
  - Last edge at T+1+(2*DATA_W)*H.
  - rsp_valid at last edge +1.
  - cs_n rises at T+1+(2*DATA_W+2)*H.
  - With DATA_W=8, H=1: cs_n low for exactly 18 cycles.
- Back-to-back frames from GAP add no extra idle cycles beyond SETUP/HOLD; cs_n never glitches high between frames.
- A req_valid that arrives while in SETUP/SHIFT/HOLD is stalled (req_ready=0); req_data must stay stable until the handshake.
- Changing cfg_* while busy has no effect on the current transaction.

## Structure
- Package spi_pkg:
  - state enum spi_state_e (IDLE, SETUP, SHIFT, HOLD, GAP)
  - DIV_W/DATA_W defaults
  - CPOL/CPHA mode constants
- Sub-module spi_clk_gen:
  - Inputs: div, cnt_clr, en.
  - Outputs: one-cycle half-period `tick` strobe and edge index counter (0..2*DATA_W).
- spi_master_ctrl contains the FSM, shift registers and output registers.

## Test plan
- Mode 0, cfg_div=0, req_data=8'hA5, req_last=1, MISO loopback:
  - MOSI bits 1,0,1,0,0,1,0,1 on leading edges.
  - rsp_data=8'hA5.
  - cs_n low exactly 18 cycles.
- Mode 3 (cpol=1, cpha=1), cfg_div=3, req_data=8'h3C, MISO driven 8'hC3:
  - sclk idles high; half-period 4 cycles.
  - Sampling on rising (trailing) edges.
  - rsp_data=8'hC3.
- Two frames 8'h01 (last=0) then 8'h02 (last=1) issued back-to-back:
  - cs_n stays low across both frames.
  - Two rsp_valid pulses.
  - busy drops one cycle after cs_n rises.
- req_valid held during SHIFT; cfg_div changed from 0 to 5 mid-frame:
  - req_ready=0 until IDLE.
  - Current frame keeps half-period 1.
  - Next frame uses 6.
- rst_n asserted at SHIFT edge 7:
  - cs_n=1, sclk=0, busy=0 immediately; no rsp_valid.
  - After release, a new frame completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master controller slice.
package spi_pkg;

    localparam int DIV_W_DEF  = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic CPOL_IDLE_LOW  = 1'b0;
    localparam logic CPOL_IDLE_HIGH = 1'b1;
    localparam logic CPHA_LEAD      = 1'b0;
    localparam logic CPHA_TRAIL     = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator and SCLK edge index counter; everything stays on clk.
module spi_clk_gen #(
    parameter int DIV_W  = 8,
    parameter int DATA_W = 8,
    parameter int EDGE_W = $clog2(2*DATA_W+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              cnt_clr,
    input  logic              en,
    output logic              tick,
    output logic [EDGE_W-1:0] edge_idx
);

    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W);

    logic [DIV_W-1:0]  r_cnt;
    logic [EDGE_W-1:0] r_edge;

    assign tick     = en && (r_cnt == div);
    assign edge_idx = r_edge;

    // Edge index saturates at the final edge so HOLD can reuse the same ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_edge <= '0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_edge <= '0;
        end else begin
            if (cnt_clr || (r_cnt == div))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (tick && (r_edge != LAST_EDGE))
                r_edge <= r_edge + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transfer controller: request handshake, CS/SCLK/MOSI sequencing,
// MISO capture and per-frame response strobe.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_last,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int EDGE_W = $clog2(2*DATA_W+1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W);
    localparam logic [EDGE_W-1:0] FINAL_IDX = EDGE_W'(2*DATA_W-1);

    spi_state_e        r_state;
    logic [DIV_W-1:0]  r_div;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_last;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs_n;
    logic              r_busy;
    logic              r_rsp_valid;
    logic              r_rsp_pend;
    logic [DATA_W-1:0] r_rsp_data;

    logic              w_tick;
    logic [EDGE_W-1:0] w_edge_idx;
    logic              w_en;
    logic              w_cnt_clr;
    logic              w_hs;
    logic              w_do_edge;
    logic              w_lead;
    logic              w_final;
    logic              w_sample;

    assign req_ready = (r_state == IDLE) || (r_state == GAP);
    assign w_hs      = req_valid && req_ready;
    assign w_en      = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
    assign w_cnt_clr = w_tick && ((r_state == SETUP) || (r_state == HOLD) ||
                                  ((r_state == SHIFT) && (w_edge_idx == LAST_EDGE)));

    // The SETUP->SHIFT tick is itself edge 1; edge number = edge_idx + 1.
    assign w_do_edge = w_tick && ((r_state == SETUP) ||
                                  ((r_state == SHIFT) && (w_edge_idx != LAST_EDGE)));
    assign w_lead    = ~w_edge_idx[0];
    assign w_final   = w_do_edge && (w_edge_idx == FINAL_IDX);
    assign w_sample  = w_lead ^ r_cpha;

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
    assign sclk      = r_sclk;
    assign mosi      = r_mosi;
    assign cs_n      = r_cs_n;

    spi_clk_gen #(
        .DIV_W  (DIV_W),
        .DATA_W (DATA_W),
        .EDGE_W (EDGE_W)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .div      (r_div),
        .cnt_clr  (w_cnt_clr),
        .en       (w_en),
        .tick     (w_tick),
        .edge_idx (w_edge_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_cpol      <= CPOL_IDLE_LOW;
            r_cpha      <= CPHA_LEAD;
            r_last      <= 1'b1;
            r_tx        <= '0;
            r_rx        <= '0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_pend  <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_pend) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_rx;
                r_rsp_pend  <= 1'b0;
            end

            if (w_do_edge) begin
                r_sclk <= ~r_sclk;
                if (w_sample) begin
                    r_rx <= {r_rx[DATA_W-2:0], miso};
                end else if (!w_final) begin
                    r_mosi <= r_tx[DATA_W-1];
                    r_tx   <= r_tx << 1;
                end
                if (w_final)
                    r_rsp_pend <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_sclk <= cfg_cpol;
                    r_cs_n <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_hs) begin
                        r_div   <= cfg_div;
                        r_cpol  <= cfg_cpol;
                        r_cpha  <= cfg_cpha;
                        r_last  <= req_last;
                        r_rx    <= '0;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                        // CPHA=0 must present the MSB before the first leading edge.
                        if (cfg_cpha == CPHA_LEAD) begin
                            r_mosi <= req_data[DATA_W-1];
                            r_tx   <= req_data << 1;
                        end else begin
                            r_tx   <= req_data;
                        end
                    end
                end
                SETUP: begin
                    if (w_tick)
                        r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_tick && (w_edge_idx == LAST_EDGE))
                        r_state <= HOLD;
                end
                HOLD: begin
                    if (w_tick) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_cs_n  <= 1'b1;
                        end else begin
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (w_hs) begin
                        r_last  <= req_last;
                        r_rx    <= '0;
                        r_state <= SETUP;
                        if (r_cpha == CPHA_LEAD) begin
                            r_mosi <= req_data[DATA_W-1];
                            r_tx   <= req_data << 1;
                        end else begin
                            r_tx   <= req_data;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: loopback / slave-model MISO, timing checks.
module tb_spi_master_ctrl;

    localparam int DIV_W  = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cfg_cpol = 1'b0;
    logic              cfg_cpha = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] req_data = '0;
    logic              req_last = 1'b0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs_n;

    spi_master_ctrl #(.DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_div   (cfg_div),
        .cfg_cpol  (cfg_cpol),
        .cfg_cpha  (cfg_cpha),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard and monitor state
    logic [DATA_W-1:0] rsp_q[$];
    logic              mosi_q[$];
    int                cs_len_q[$];
    bit                tb_loop = 1'b1;
    bit                mosi_chk = 1'b0;
    logic              mon_cpol = 1'b0;
    logic              sl_cpha = 1'b0;
    logic [DATA_W-1:0] sl_tx = '0;
    logic              miso_sl = 1'b0;
    logic              prev_cs_n = 1'b1;
    logic              prev_sclk = 1'b0;
    logic              prev_busy = 1'b0;
    int cs_run = 0, edge_cnt = 0, last_chg = -1, last_half = 0;
    int rsp_cnt = 0, rsp_cyc = 0, cs_rise_cyc = 0, busy_fall_cyc = 0, hs_cyc = 0;

    assign miso = tb_loop ? mosi : miso_sl;

    always @(negedge clk) begin
        if (!cs_n) begin
            if (prev_cs_n) begin
                cs_run   = 0;
                edge_cnt = 0;
                last_chg = -1;
            end
            cs_run++;
            if (sclk != prev_sclk) begin
                edge_cnt++;
                if (last_chg >= 0) last_half = cyc - last_chg;
                last_chg = cyc;
                if (mosi_chk && (sclk != mon_cpol) && (mosi_q.size() > 0))
                    check_eq("mosi_bit", mosi, mosi_q.pop_front());
                if (sl_cpha && (sclk != mon_cpol)) begin
                    miso_sl = sl_tx[DATA_W-1];
                    sl_tx   = sl_tx << 1;
                end
            end
        end else if (!prev_cs_n) begin
            cs_len_q.push_back(cs_run);
            cs_rise_cyc = cyc;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (rsp_q.size() == 0) check_eq("rsp_spurious", rsp_valid, 0);
            else                   check_eq("rsp_data", rsp_data, rsp_q.pop_front());
        end
        prev_cs_n = cs_n;
        prev_sclk = sclk;
        prev_busy = busy;
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic last);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = d;
        req_last  = last;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_eq("hs_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        hs_cyc    = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || !cs_n) && n < 5000);
        if (busy) check_eq("idle_timeout", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic int pop_len();
        if (cs_len_q.size() == 0) return -1;
        return cs_len_q.pop_front();
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int n;
        logic [DATA_W-1:0] a5;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_cs_n", cs_n, 1);
        check_eq("rst_mosi", mosi, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req_ready", req_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, H=1, loopback, A5
        a5 = 8'hA5;
        for (int i = DATA_W - 1; i >= 0; i--) mosi_q.push_back(a5[i]);
        mosi_chk = 1'b1;
        rsp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        wait_idle();
        mosi_chk = 1'b0;
        check_eq("m0_mosi_left", mosi_q.size(), 0);
        check_eq("m0_cs_len", pop_len(), 18);
        check_eq("m0_rsp_lat", rsp_cyc - hs_cyc, 17);
        check_eq("m0_half", last_half, 1);

        // Mode 3, H=4, slave returns C3
        tb_loop  = 1'b0;
        sl_cpha  = 1'b1;
        mon_cpol = 1'b1;
        cfg_cpol = 1'b1;
        cfg_cpha = 1'b1;
        cfg_div  = 8'd3;
        sl_tx    = 8'hC3;
        repeat (3) @(negedge clk);
        check_eq("m3_idle_sclk", sclk, 1);
        rsp_q.push_back(8'hC3);
        send(8'h3C, 1'b1);
        wait_idle();
        check_eq("m3_cs_len", pop_len(), 72);
        check_eq("m3_half", last_half, 4);
        check_eq("m3_rsp_lat", rsp_cyc - hs_cyc, 65);
        check_eq("m3_end_sclk", sclk, 1);

        // Back-to-back frames through GAP
        tb_loop  = 1'b1;
        sl_cpha  = 1'b0;
        mon_cpol = 1'b0;
        cfg_cpol = 1'b0;
        cfg_cpha = 1'b0;
        cfg_div  = 8'd0;
        repeat (3) @(negedge clk);
        rc0 = rsp_cnt;
        rsp_q.push_back(8'h01);
        rsp_q.push_back(8'h02);
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        wait_idle();
        check_eq("b2b_cs_len", pop_len(), 37);
        check_eq("b2b_rsp_cnt", rsp_cnt - rc0, 2);
        check_eq("b2b_busy_lag", busy_fall_cyc - cs_rise_cyc, 1);

        // Stall during SHIFT, cfg_div change mid-frame
        rsp_q.push_back(8'h96);
        send(8'h96, 1'b1);
        repeat (4) @(negedge clk);
        cfg_div   = 8'd5;
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = 8'h5A;
        req_last  = 1'b1;
        #1;
        check_eq("stall_ready", req_ready, 0);
        rsp_q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        check_eq("stall_until_idle", hs_cyc - cs_rise_cyc, 1);
        wait_idle();
        check_eq("cfg_frame1_len", pop_len(), 18);
        check_eq("cfg_frame2_len", pop_len(), 108);
        check_eq("cfg_frame2_lat", rsp_cyc - hs_cyc, 97);
        cfg_div = 8'd0;
        repeat (2) @(negedge clk);

        // Reset at SHIFT edge 7, then a clean frame
        send(8'h0F, 1'b1);
        n = 0;
        while (edge_cnt != 7 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("rst_edge_reached", edge_cnt, 7);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cs_n", cs_n, 1);
        check_eq("mid_rst_sclk", sclk, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_rsp_data", rsp_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cs_len_q.delete();
        repeat (2) @(negedge clk);
        rsp_q.push_back(8'hC3);
        send(8'hC3, 1'b1);
        wait_idle();
        check_eq("post_rst_cs_len", pop_len(), 18);
        check_eq("rsp_q_drained", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
